// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write arbiter and its scoreboard.
package rf_pkg;

  localparam int unsigned RF_AW         = 5;
  localparam int unsigned RF_DW         = 32;
  localparam int unsigned RF_STARVE_MAX = 3;

  typedef enum logic {
    GNT_A,
    GNT_B
  } grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared when the write lands.
module rf_scoreboard #(
  parameter int unsigned AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic          flush_i,
  input  logic [AW-1:0] rs_addr_i,
  input  logic [AW-1:0] rt_addr_i,
  output logic          rs_pend_o,
  output logic          rt_pend_o
);

  localparam int unsigned NumRegs = 2 ** AW;

  logic [NumRegs-1:0] pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end else begin
      if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
      // Set is applied after clear so a same-edge re-reservation survives.
      if (set_en_i && (set_addr_i != '0)) pend_d[set_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign rs_pend_o = (rs_addr_i != '0) && pend_q[rs_addr_i];
  assign rt_pend_o = (rt_addr_i != '0) && pend_q[rt_addr_i];

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates two writeback sources onto the single register-file write port, with
// starvation protection for the slow source and a pending-write scoreboard for decode.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DW         = RF_DW,
  parameter int unsigned AW         = RF_AW,
  parameter int unsigned STARVE_MAX = RF_STARVE_MAX
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          A_Valid,
  input  logic [AW-1:0] A_Addr,
  input  logic [DW-1:0] A_Data,
  output logic          A_Ready,
  input  logic          B_Valid,
  input  logic [AW-1:0] B_Addr,
  input  logic [DW-1:0] B_Data,
  output logic          B_Ready,
  input  logic          Res_Valid,
  input  logic [AW-1:0] Res_Addr,
  input  logic          Flush,
  input  logic [AW-1:0] RsAddr,
  input  logic [AW-1:0] RtAddr,
  output logic          RsPend,
  output logic          RtPend,
  output logic [AW-1:0] WrAddr,
  output logic [DW-1:0] DataIn,
  output logic          RegWr
);

  localparam logic [2:0] StarveMax = 3'(STARVE_MAX);

  grant_e        gnt;
  logic          xfer;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  logic [2:0]    starve_q, starve_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          reg_wr_q, reg_wr_d;

  always_comb begin
    gnt = GNT_A;
    if (B_Valid && (!A_Valid || (starve_q == StarveMax))) gnt = GNT_B;
  end

  assign xfer     = A_Valid | B_Valid;
  assign A_Ready  = A_Valid && (gnt == GNT_A);
  assign B_Ready  = B_Valid && (gnt == GNT_B);
  assign win_addr = (gnt == GNT_B) ? B_Addr : A_Addr;
  assign win_data = (gnt == GNT_B) ? B_Data : A_Data;

  always_comb begin
    starve_d = starve_q;
    if (!B_Valid || B_Ready) begin
      starve_d = '0;
    end else if (starve_q != StarveMax) begin
      starve_d = starve_q + 3'd1;
    end
  end

  // Address/data hold their last value when idle; only the enable is pulsed.
  always_comb begin
    wr_addr_d = wr_addr_q;
    data_d    = data_q;
    reg_wr_d  = 1'b0;
    if (xfer) begin
      wr_addr_d = win_addr;
      data_d    = win_data;
      reg_wr_d  = (win_addr != '0);
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      starve_q  <= '0;
      wr_addr_q <= '0;
      data_q    <= '0;
      reg_wr_q  <= 1'b0;
    end else begin
      starve_q  <= starve_d;
      wr_addr_q <= wr_addr_d;
      data_q    <= data_d;
      reg_wr_q  <= reg_wr_d;
    end
  end

  assign WrAddr = wr_addr_q;
  assign DataIn = data_q;
  assign RegWr  = reg_wr_q;

  rf_scoreboard #(
    .AW(AW)
  ) u_scoreboard (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .set_en_i  (Res_Valid),
    .set_addr_i(Res_Addr),
    .clr_en_i  (reg_wr_q),
    .clr_addr_i(wr_addr_q),
    .flush_i   (Flush),
    .rs_addr_i (RsAddr),
    .rt_addr_i (RtAddr),
    .rs_pend_o (RsPend),
    .rt_pend_o (RtPend)
  );

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: arbitration, starvation, $0 handling, scoreboard, reset.
module tb_rf_write_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        A_Valid, B_Valid, Res_Valid, Flush;
  logic [4:0]  A_Addr, B_Addr, Res_Addr, RsAddr, RtAddr;
  logic [31:0] A_Data, B_Data;
  logic        A_Ready, B_Ready, RsPend, RtPend, RegWr;
  logic [4:0]  WrAddr;
  logic [31:0] DataIn;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  rf_write_arbiter dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .A_Valid  (A_Valid),
    .A_Addr   (A_Addr),
    .A_Data   (A_Data),
    .A_Ready  (A_Ready),
    .B_Valid  (B_Valid),
    .B_Addr   (B_Addr),
    .B_Data   (B_Data),
    .B_Ready  (B_Ready),
    .Res_Valid(Res_Valid),
    .Res_Addr (Res_Addr),
    .Flush    (Flush),
    .RsAddr   (RsAddr),
    .RtAddr   (RtAddr),
    .RsPend   (RsPend),
    .RtPend   (RtPend),
    .WrAddr   (WrAddr),
    .DataIn   (DataIn),
    .RegWr    (RegWr)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    A_Valid = 0; A_Addr = 0; A_Data = 0;
    B_Valid = 0; B_Addr = 0; B_Data = 0;
    Res_Valid = 0; Res_Addr = 0; Flush = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RsAddr = 5'd1; RtAddr = 5'd2;
    Rst_n = 0;
    tick(); tick();
    checks++;
    if (RegWr !== 1'b0 || WrAddr !== 5'd0 || DataIn !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got RegWr=%0b WrAddr=%0d DataIn=%h want 0/0/0",
               RegWr, WrAddr, DataIn);
    end
    checks++;
    if (RsPend !== 1'b0 || RtPend !== 1'b0) begin
      errors++;
      $display("FAIL reset_pend: got Rs=%0b Rt=%0b want 0/0", RsPend, RtPend);
    end
    Rst_n = 1;
    tick();
  endtask

  task automatic test_single_a();
    A_Valid = 1; A_Addr = 5'd5; A_Data = 32'hDEADBEEF;
    #1;
    checks++;
    if (A_Ready !== 1'b1 || B_Ready !== 1'b0) begin
      errors++;
      $display("FAIL single_a_ready: got A=%0b B=%0b want 1/0", A_Ready, B_Ready);
    end
    tick();
    A_Valid = 0;
    checks++;
    if (RegWr !== 1'b1 || WrAddr !== 5'd5 || DataIn !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_a_write: got RegWr=%0b WrAddr=%0d DataIn=%h want 1/5/deadbeef",
               RegWr, WrAddr, DataIn);
    end
    tick();
    checks++;
    if (RegWr !== 1'b0) begin
      errors++;
      $display("FAIL single_a_idle: got RegWr=%0b want 0", RegWr);
    end
  endtask

  task automatic test_starvation();
    // Expected winners with both valid: A A A B A A A B (1 = B granted).
    logic [7:0] b_wins;
    b_wins = 8'b1000_1000;
    B_Valid = 1; B_Addr = 5'd2; B_Data = 32'h2222_2222;
    #1;
    checks++;
    if (B_Ready !== 1'b1) begin
      errors++;
      $display("FAIL b_alone_ready: got %0b want 1", B_Ready);
    end
    tick();
    A_Valid = 1; A_Addr = 5'd1; A_Data = 32'h1111_1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (A_Ready !== !b_wins[c] || B_Ready !== b_wins[c]) begin
        errors++;
        $display("FAIL starve_grant_c%0d: got A=%0b B=%0b want A=%0b B=%0b",
                 c, A_Ready, B_Ready, !b_wins[c], b_wins[c]);
      end
      tick();
      checks++;
      if (WrAddr !== (b_wins[c] ? 5'd2 : 5'd1) || RegWr !== 1'b1) begin
        errors++;
        $display("FAIL starve_wr_c%0d: got WrAddr=%0d RegWr=%0b want %0d/1",
                 c, WrAddr, RegWr, b_wins[c] ? 2 : 1);
      end
      if (c == 3) begin
        checks++;
        if (dut.starve_q !== 3'd0) begin
          errors++;
          $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_q);
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reg0();
    A_Valid = 1; A_Addr = 5'd0; A_Data = 32'h1234;
    #1;
    checks++;
    if (A_Ready !== 1'b1) begin
      errors++;
      $display("FAIL reg0_ready: got %0b want 1", A_Ready);
    end
    tick();
    A_Valid = 0;
    checks++;
    if (RegWr !== 1'b0) begin
      errors++;
      $display("FAIL reg0_regwr: got %0b want 0", RegWr);
    end
    Res_Valid = 1; Res_Addr = 5'd0; RsAddr = 5'd0;
    tick();
    Res_Valid = 0;
    checks++;
    if (RsPend !== 1'b0) begin
      errors++;
      $display("FAIL reg0_pend: got %0b want 0", RsPend);
    end
  endtask

  task automatic test_scoreboard();
    RsAddr = 5'd7; RtAddr = 5'd7;
    Res_Valid = 1; Res_Addr = 5'd7;
    tick();
    Res_Valid = 0;
    checks++;
    if (RsPend !== 1'b1 || RtPend !== 1'b1) begin
      errors++;
      $display("FAIL sb_reserve: got Rs=%0b Rt=%0b want 1/1", RsPend, RtPend);
    end
    B_Valid = 1; B_Addr = 5'd7; B_Data = 32'h77;
    tick();
    B_Valid = 0;
    checks++;
    if (RegWr !== 1'b1 || WrAddr !== 5'd7 || RsPend !== 1'b1) begin
      errors++;
      $display("FAIL sb_write_cycle: got RegWr=%0b WrAddr=%0d RsPend=%0b want 1/7/1",
               RegWr, WrAddr, RsPend);
    end
    tick();
    checks++;
    if (RsPend !== 1'b0) begin
      errors++;
      $display("FAIL sb_cleared: got %0b want 0", RsPend);
    end
    // Collision: reserve again, write, then re-reserve on the clearing edge.
    Res_Valid = 1; Res_Addr = 5'd7;
    tick();
    Res_Valid = 0;
    A_Valid = 1; A_Addr = 5'd7; A_Data = 32'h7777;
    tick();
    A_Valid = 0;
    Res_Valid = 1; Res_Addr = 5'd7;
    tick();
    Res_Valid = 0;
    checks++;
    if (RsPend !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_wins: got %0b want 1", RsPend);
    end
    A_Valid = 1; A_Addr = 5'd7; A_Data = 32'h7;
    tick();
    A_Valid = 0;
    tick();
    checks++;
    if (RsPend !== 1'b0) begin
      errors++;
      $display("FAIL sb_final_clear: got %0b want 0", RsPend);
    end
  endtask

  task automatic test_flush();
    Res_Valid = 1; Res_Addr = 5'd3;
    tick();
    Res_Addr = 5'd9;
    tick();
    Res_Valid = 0;
    RsAddr = 5'd3; RtAddr = 5'd9;
    #1;
    checks++;
    if (RsPend !== 1'b1 || RtPend !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre: got Rs=%0b Rt=%0b want 1/1", RsPend, RtPend);
    end
    A_Valid = 1; A_Addr = 5'd3; A_Data = 32'h3333;
    Flush = 1; Res_Valid = 1; Res_Addr = 5'd4;
    tick();
    idle_inputs();
    checks++;
    if (RsPend !== 1'b0 || RtPend !== 1'b0) begin
      errors++;
      $display("FAIL flush_pend: got Rs=%0b Rt=%0b want 0/0", RsPend, RtPend);
    end
    checks++;
    if (RegWr !== 1'b1 || WrAddr !== 5'd3 || DataIn !== 32'h3333) begin
      errors++;
      $display("FAIL flush_write: got RegWr=%0b WrAddr=%0d DataIn=%h want 1/3/3333",
               RegWr, WrAddr, DataIn);
    end
    RsAddr = 5'd4;
    #1;
    checks++;
    if (RsPend !== 1'b0) begin
      errors++;
      $display("FAIL flush_res_ignored: got %0b want 0", RsPend);
    end
    tick();
  endtask

  task automatic test_async_reset();
    Res_Valid = 1; Res_Addr = 5'd12; RsAddr = 5'd12;
    tick();
    Res_Valid = 0;
    A_Valid = 1; A_Addr = 5'd10; A_Data = 32'hAA;
    B_Valid = 1; B_Addr = 5'd11; B_Data = 32'hBB;
    tick();
    idle_inputs();
    checks++;
    if (RegWr !== 1'b1 || dut.starve_q !== 3'd1 || RsPend !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got RegWr=%0b starve=%0d RsPend=%0b want 1/1/1",
               RegWr, dut.starve_q, RsPend);
    end
    #2;
    Rst_n = 0;
    #1;
    checks++;
    if (RegWr !== 1'b0 || WrAddr !== 5'd0 || DataIn !== 32'd0) begin
      errors++;
      $display("FAIL areset_outputs: got RegWr=%0b WrAddr=%0d DataIn=%h want 0/0/0",
               RegWr, WrAddr, DataIn);
    end
    checks++;
    if (RsPend !== 1'b0 || dut.starve_q !== 3'd0) begin
      errors++;
      $display("FAIL areset_state: got RsPend=%0b starve=%0d want 0/0", RsPend, dut.starve_q);
    end
    tick();
    Rst_n = 1;
    #1;
    checks++;
    if (RegWr !== 1'b0) begin
      errors++;
      $display("FAIL areset_release: got RegWr=%0b want 0", RegWr);
    end
    A_Valid = 1; A_Addr = 5'd6; A_Data = 32'h66;
    tick();
    A_Valid = 0;
    checks++;
    if (RegWr !== 1'b1 || WrAddr !== 5'd6 || DataIn !== 32'h66) begin
      errors++;
      $display("FAIL areset_first_write: got RegWr=%0b WrAddr=%0d DataIn=%h want 1/6/66",
               RegWr, WrAddr, DataIn);
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_starvation();
    test_reg0();
    test_scoreboard();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
